// File: rtl/fa_pkg.sv
// Shared definitions for the pooling engine: reduction modes, FSM state
// encoding and the helpers that derive counter/accumulator widths.
package fa_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ACCUM = 3'd1;
    localparam state_t ST_CALC  = 3'd2;
    localparam state_t ST_EMIT  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Counter wide enough to hold the value max_val itself.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    // Sum of up to win_max sign-extended elements never overflows this width.
    function automatic int acc_w(input int data_w, input int win_max);
        return data_w + $clog2(win_max);
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel of the pooling datapath.
// Keeps the running max / running sum for the current window and produces
// the registered per-lane result: the max directly, or the average as
// (sum * recip) >>> RECIP_W saturated to DATA_W.
// Optional build macro: POOL_ROUND_EN (round half up before the shift).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   beat_en     element accepted this cycle
//   first       accepted element is the first of its window
//   capture     last element of a MAX window: load res with the final max
//   calc_en     AVG divide cycle: load res with the scaled sum
//   mode        POOL_MAX / POOL_AVG
//   recip       unsigned Q0.RECIP_W reciprocal of the window size
//   x           incoming element (signed)
//   res         registered result for this lane
module pool_lane import fa_pkg::*; #(
    parameter int DATA_W  = 16,
    parameter int RECIP_W = 16,
    parameter int ACC_W   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               beat_en,
    input  logic               first,
    input  logic               capture,
    input  logic               calc_en,
    input  logic               mode,
    input  logic [RECIP_W-1:0] recip,
    input  logic [DATA_W-1:0]  x,
    output logic [DATA_W-1:0]  res
);

    localparam int PROD_W = ACC_W + RECIP_W + 1;
    localparam int QUOT_W = ACC_W + 1;

    localparam logic signed [QUOT_W-1:0] SAT_HI = (QUOT_W'(1) << (DATA_W - 1)) - QUOT_W'(1);
    localparam logic signed [QUOT_W-1:0] SAT_LO = -(QUOT_W'(1) << (DATA_W - 1));

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  xs;
    logic signed [ACC_W-1:0]  max_val;
    logic signed [ACC_W-1:0]  sum_val;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_adj;
    logic signed [QUOT_W-1:0] quot;
    logic [DATA_W-1:0]        avg_res;

    assign xs      = {{(ACC_W - DATA_W){x[DATA_W-1]}}, x};
    assign max_val = first ? xs : ((xs > acc) ? xs : acc);
    assign sum_val = first ? xs : acc + xs;

    // recip is unsigned: zero-extend before the signed multiply.
    assign prod = PROD_W'(acc) * PROD_W'($signed({1'b0, recip}));

`ifdef POOL_ROUND_EN
    assign prod_adj = prod + (PROD_W'(1) << (RECIP_W - 1));
`else
    assign prod_adj = prod;
`endif

    // Arithmetic shift = keep the upper bits of a signed value (floor).
    assign quot = prod_adj[PROD_W-1:RECIP_W];

    always_comb begin
        avg_res = quot[DATA_W-1:0];
        if (quot > SAT_HI)
            avg_res = SAT_HI[DATA_W-1:0];
        else if (quot < SAT_LO)
            avg_res = SAT_LO[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            res <= '0;
        end else begin
            if (beat_en)
                acc <= (mode == POOL_AVG) ? sum_val : max_val;
            if (capture)
                res <= max_val[DATA_W-1:0];
            else if (calc_en)
                res <= avg_res;
        end
    end

endmodule

// File: rtl/pool_core.sv
// Streaming pooling engine. Accepts one command, then reduces num_out
// windows of win elements each (MAX or AVG per lane) and emits one result
// beat per window.
// Optional build macro: POOL_ROUND_EN (AVG rounds half up instead of
// truncating toward -inf; latency unchanged).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cfg_mode/win/num_out/recip      command fields, latched on accept
//   in_valid/in_ready/in_data       element stream, lane 0 in the LSBs
//   out_valid/out_ready/out_data    result stream, registered
//   busy                            not IDLE
//   done                            one-cycle pulse after the last result
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for a command
// ACCUM    | accepting elements of the current window
// CALC     | AVG only: scale sum by reciprocal, saturate
// EMIT     | result beat offered downstream
// DONE     | command complete, done pulse
module pool_core import fa_pkg::*; #(
    parameter int DATA_W  = 16,
    parameter int LANES   = 4,
    parameter int WIN_MAX = 256,
    parameter int OUT_MAX = 65536,
    parameter int RECIP_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cfg_mode,
    input  logic [cnt_w(WIN_MAX)-1:0]     cfg_win,
    input  logic [cnt_w(OUT_MAX)-1:0]     cfg_num_out,
    input  logic [RECIP_W-1:0]            cfg_recip,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_W-1:0]       in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_W-1:0]       out_data,
    output logic                          busy,
    output logic                          done
);

    localparam int WIN_W = cnt_w(WIN_MAX);
    localparam int OUT_W = cnt_w(OUT_MAX);
    localparam int ACC_W = acc_w(DATA_W, WIN_MAX);

    state_t               state;
    logic                 mode_q;
    logic [WIN_W-1:0]     win_q;
    logic [OUT_W-1:0]     num_out_q;
    logic [RECIP_W-1:0]   recip_q;
    logic [WIN_W-1:0]     elem_cnt;
    logic [OUT_W-1:0]     out_cnt;

    logic in_fire;
    logic out_fire;
    logic last_elem;
    logic last_out;

    assign cmd_ready = (state == ST_IDLE);
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_EMIT);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    assign in_fire   = in_ready && in_valid;
    assign out_fire  = out_valid && out_ready;
    assign last_elem = (elem_cnt == win_q - WIN_W'(1));
    assign last_out  = (out_cnt == num_out_q - OUT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= POOL_MAX;
            win_q     <= '0;
            num_out_q <= '0;
            recip_q   <= '0;
            elem_cnt  <= '0;
            out_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mode_q    <= cfg_mode;
                        win_q     <= cfg_win;
                        num_out_q <= cfg_num_out;
                        recip_q   <= cfg_recip;
                        elem_cnt  <= '0;
                        out_cnt   <= '0;
                        state     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_fire) begin
                        elem_cnt <= elem_cnt + WIN_W'(1);
                        if (last_elem)
                            state <= (mode_q == POOL_AVG) ? ST_CALC : ST_EMIT;
                    end
                end
                ST_CALC: state <= ST_EMIT;
                ST_EMIT: begin
                    if (out_fire) begin
                        out_cnt  <= out_cnt + OUT_W'(1);
                        elem_cnt <= '0;
                        state    <= last_out ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pool_lane #(
            .DATA_W  (DATA_W),
            .RECIP_W (RECIP_W),
            .ACC_W   (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .beat_en (in_fire),
            .first   (elem_cnt == '0),
            .capture (in_fire && last_elem && (mode_q == POOL_MAX)),
            .calc_en (state == ST_CALC),
            .mode    (mode_q),
            .recip   (recip_q),
            .x       (in_data[g*DATA_W +: DATA_W]),
            .res     (out_data[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_pool_core.sv
module tb_pool_core;

    localparam int DATA_W  = 16;
    localparam int LANES   = 4;
    localparam int WIN_MAX = 256;
    localparam int OUT_MAX = 65536;
    localparam int RECIP_W = 16;
    localparam int WIN_W   = $clog2(WIN_MAX) + 1;
    localparam int OUT_W   = $clog2(OUT_MAX) + 1;

`ifdef POOL_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cfg_mode;
    logic [WIN_W-1:0]           cfg_win;
    logic [OUT_W-1:0]           cfg_num_out;
    logic [RECIP_W-1:0]         cfg_recip;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*DATA_W-1:0]    in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*DATA_W-1:0]    out_data;
    logic                       busy;
    logic                       done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    pool_core #(
        .DATA_W  (DATA_W),
        .LANES   (LANES),
        .WIN_MAX (WIN_MAX),
        .OUT_MAX (OUT_MAX),
        .RECIP_W (RECIP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cfg_mode    (cfg_mode),
        .cfg_win     (cfg_win),
        .cfg_num_out (cfg_num_out),
        .cfg_recip   (cfg_recip),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    always @(posedge clk) begin
        if (rst_n && cmd_valid && cmd_ready)
            assert (cfg_win >= 1 && cfg_win <= WIN_MAX &&
                    cfg_num_out >= 1 && cfg_num_out <= OUT_MAX)
            else $error("cfg out of range win=%0d num_out=%0d", cfg_win, cfg_num_out);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic send_cmd(input logic m, input int w, input int n, input logic [15:0] r);
        int t = 0;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cfg_mode    = m;
        cfg_win     = WIN_W'(w);
        cfg_num_out = OUT_W'(n);
        cfg_recip   = r;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("cmd_timeout", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push(input logic [63:0] d, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_out(input string tag, input logic [63:0] exp, input int stall);
        int t = 0;
        while (!out_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
        end else begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk({tag, "_hold"}, out_data, exp);
                chk({tag, "_hold_inrdy"}, 64'(in_ready), 64'd0);
                chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            end
            chk(tag, out_data, exp);
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    // Called at the negedge right after the final result was accepted.
    task automatic finish_cmd(input string tag, input int base);
        chk({tag, "_done_hi"}, 64'(done), 64'd1);
        @(negedge clk);
        chk({tag, "_done_lo"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_done_cnt"}, 64'(done_cnt - base), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_done"},      64'(done),      64'd0);
        chk({tag, "_out_data"},  out_data,       64'd0);
    endtask

    initial begin
        int base;
        int l0 [9];
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cfg_mode    = 1'b0;
        cfg_win     = '0;
        cfg_num_out = '0;
        cfg_recip   = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;

        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // MAX 3x3, two windows
        l0 = '{-5, 3, 7, -1, 0, 2, 7, 1, -8};
        base = done_cnt;
        send_cmd(1'b0, 9, 2, 16'h0);
        chk("max_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 9; i++) push(pk(l0[i], i, -i, 100), 0);
        chk("max_lat", 64'(out_valid), 64'd1);
        get_out("max_w0", pk(7, 8, 0, 100), 0);
        for (int i = 0; i < 9; i++) push(pk(-3, -3, -3, -3), 0);
        get_out("max_w1", pk(-3, -3, -3, -3), 0);
        finish_cmd("max", base);

        // AVG win=4, sum 11 / -11 / 16 / 0
        base = done_cnt;
        send_cmd(1'b1, 4, 1, 16'h4000);
        push(pk(1, -1, 4, 0), 0);
        push(pk(2, -2, 4, 0), 0);
        push(pk(3, -3, 4, 0), 0);
        push(pk(5, -5, 4, 0), 0);
        chk("avg_lat0", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("avg_lat1", 64'(out_valid), 64'd1);
        get_out("avg4", RND ? pk(3, -3, 4, 0) : pk(2, -3, 4, 0), 0);
        finish_cmd("avg4", base);

        // global average pool: 169 saturating elements per lane
        base = done_cnt;
        send_cmd(1'b1, 169, 1, 16'h0184);
        for (int i = 0; i < 169; i++) push(pk(32767, 32767, 32767, -32768), 0);
        get_out("gap", pk(32767, 32767, 32767, -32768), 0);
        finish_cmd("gap", base);

        // window of one element
        send_cmd(1'b0, 1, 2, 16'h0);
        push(pk(100, -100, 0, 1), 0);
        get_out("win1_max0", pk(100, -100, 0, 1), 0);
        push(pk(-32768, 32767, -1, 5), 0);
        get_out("win1_max1", pk(-32768, 32767, -1, 5), 0);
        @(negedge clk);
        send_cmd(1'b1, 1, 1, 16'hFFFF);
        push(pk(100, -100, 0, 1), 0);
        get_out("win1_avg", RND ? pk(100, -100, 0, 1) : pk(99, -100, 0, 0), 0);
        @(negedge clk);

        // output backpressure with the next element already waiting
        base = done_cnt;
        send_cmd(1'b0, 3, 2, 16'h0);
        push(pk(10, -7, 0, 32767), 0);
        push(pk(-20, -9, 0, -32768), 0);
        push(pk(30, -8, 0, 0), 0);
        in_valid = 1'b1;
        in_data  = pk(5, 1, 1, 1);
        get_out("bp_w0", pk(30, -7, 0, 32767), 10);
        push(pk(5, 1, 1, 1), 0);
        push(pk(9, 2, 2, 2), 0);
        push(pk(1, 3, 3, 3), 0);
        get_out("bp_w1", pk(9, 3, 3, 3), 0);
        finish_cmd("bp", base);

        // same AVG window with random input gaps
        send_cmd(1'b1, 4, 1, 16'h4000);
        push(pk(1, -1, 4, 0), $urandom_range(0, 3));
        push(pk(2, -2, 4, 0), $urandom_range(0, 3));
        push(pk(3, -3, 4, 0), $urandom_range(0, 3));
        push(pk(5, -5, 4, 0), $urandom_range(0, 3));
        get_out("gaps_avg", RND ? pk(3, -3, 4, 0) : pk(2, -3, 4, 0), 0);
        @(negedge clk);

        // reset mid-window, then a clean command
        base = done_cnt;
        send_cmd(1'b1, 9, 1, 16'h1C72);
        for (int i = 0; i < 3; i++) push(pk(1000, -1000, 2000, 3000), 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_no_done", 64'(done_cnt - base), 64'd0);
        send_cmd(1'b1, 4, 1, 16'h4000);
        push(pk(1, -1, 4, 0), 0);
        push(pk(2, -2, 4, 0), 0);
        push(pk(3, -3, 4, 0), 0);
        push(pk(5, -5, 4, 0), 0);
        get_out("post_abort", RND ? pk(3, -3, 4, 0) : pk(2, -3, 4, 0), 0);
        @(negedge clk);

        // command offered while busy is held off until IDLE
        send_cmd(1'b0, 2, 1, 16'h0);
        cmd_valid   = 1'b1;
        cfg_mode    = 1'b1;
        cfg_win     = WIN_W'(4);
        cfg_num_out = OUT_W'(1);
        cfg_recip   = 16'h4000;
        chk("busy_cmd_rdy", 64'(cmd_ready), 64'd0);
        push(pk(3, -4, 0, 7), 0);
        chk("busy_cmd_rdy2", 64'(cmd_ready), 64'd0);
        push(pk(9, -6, 0, 7), 0);
        get_out("busy_max", pk(9, -4, 0, 7), 0);
        chk("busy_done", 64'(done), 64'd1);
        chk("busy_done_rdy", 64'(cmd_ready), 64'd0);
        begin
            int t = 0;
            while (!cmd_ready && t < 10) begin
                @(negedge clk);
                t++;
            end
            chk("held_cmd_rdy", 64'(cmd_ready), 64'd1);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("held_cmd_busy", 64'(busy), 64'd1);
        push(pk(1, -1, 4, 0), 0);
        push(pk(2, -2, 4, 0), 0);
        push(pk(3, -3, 4, 0), 0);
        push(pk(5, -5, 4, 0), 0);
        get_out("held_avg", RND ? pk(3, -3, 4, 0) : pk(2, -3, 4, 0), 0);
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
